seq_mul32: RTL and testbench

SEQ_MUL32 -- requirements
Module: seq_mul32

---
 rtl/seq_mul32_pkg.sv | 16 +
 rtl/RCA32.sv | 27 ++
 rtl/seq_mul32.sv | 111 +++++++++++
 tb/tb_seq_mul32.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seq_mul32_pkg.sv
// Shared definitions for the 32x32 sequential shift/add multiplier.
// Holds the controller state encoding and the datapath widths.
// Imported by the top level and the ripple-carry adder.
package seq_mul32_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_mul32_pkg

// File: rtl/RCA32.sv
// 32-bit ripple-carry adder: sum = a + b + carryInput, with carry-out.
// Purely combinational, zero cycles of latency.
// No flow control; the result is valid whenever the inputs are stable.
module RCA32
  import seq_mul32_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carryInput,
  output logic [DATA_W-1:0] sum,
  output logic              carryOutput
);

  logic carry;

  // Ripple the carry bit by bit from the LSB upward
  always_comb begin
    sum   = '0;
    carry = carryInput;
    for (int i = 0; i < DATA_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    carryOutput = carry;
  end

endmodule : RCA32

// File: rtl/seq_mul32.sv
// Unsigned 32x32 -> 64 sequential multiplier, one add/shift step per cycle.
// Latency: 32 RUN cycles (start edge k -> done k+32); fewer with SEQ_MUL_EARLY_TERM_EN.
// Backpressure: start is sampled only in IDLE and ignored while busy is high.
module seq_mul32
  import seq_mul32_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS);

  state_t              state;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic [CNT_W-1:0]    count;
  logic [PROD_W-1:0]   product_q;

  logic [DATA_W-1:0]   add_sum;
  logic                add_co;
  logic [DATA_W-1:0]   sel_hi;
  logic                sel_c;
  logic [DATA_W-1:0]   step_hi;
  logic [DATA_W-1:0]   step_lo;
  logic [CNT_W-1:0]    count_nxt;
  logic                early_hit;
  logic [PROD_W-1:0]   early_prod;

  RCA32 u_rca (
    .a           (hi),
    .b           (a_q),
    .carryInput  (1'b0),
    .sum         (add_sum),
    .carryOutput (add_co)
  );

  // One add/shift step: the carry-out lands in bit 63 after the shift
  assign sel_hi    = lo[0] ? add_sum : hi;
  assign sel_c     = lo[0] & add_co;
  assign step_hi   = {sel_c, sel_hi[DATA_W-1:1]};
  assign step_lo   = {sel_hi[0], lo[DATA_W-1:1]};
  assign count_nxt = count + CNT_W'(1);

`ifdef SEQ_MUL_EARLY_TERM_EN
  // The low (32-count) bits of lo are multiplier bits not yet consumed;
  // once they are all zero the remaining steps would only shift.
  assign early_hit  = ((lo & ({DATA_W{1'b1}} >> count)) == '0);
  assign early_prod = {hi, lo} >> (LAST - count);
`else
  assign early_hit  = 1'b0;
  assign early_prod = '0;
`endif

  // Controller and datapath state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      hi        <= '0;
      lo        <= '0;
      count     <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= multiplicand;
            hi    <= '0;
            lo    <= multiplier;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (early_hit) begin
            product_q <= early_prod;
            state     <= DONE;
          end else begin
            hi    <= step_hi;
            lo    <= step_lo;
            count <= count_nxt;
            if (count_nxt == LAST) begin
              product_q <= {step_hi, step_lo};
              state     <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state == RUN) || (state == DONE);
  assign done    = (state == DONE);
  assign product = product_q;

endmodule : seq_mul32

// File: tb/tb_seq_mul32.sv
// Directed self-checking bench for seq_mul32.
// Expected products and latencies are hand-computed per vector.
// Builds with or without SEQ_MUL_EARLY_TERM_EN.
module tb_seq_mul32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int passed;
  int total;
  int pulses;

`ifdef SEQ_MUL_EARLY_TERM_EN
  localparam int LAT_B5     = 4;
  localparam int LAT_BFF    = 32;
  localparam int LAT_B0     = 1;
  localparam int LAT_B1     = 2;
  localparam int LAT_B10000 = 18;
`else
  localparam int LAT_B5     = 32;
  localparam int LAT_BFF    = 32;
  localparam int LAT_B0     = 32;
  localparam int LAT_B1     = 32;
  localparam int LAT_B10000 = 32;
`endif

  seq_mul32 #(.STEPS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply, scramble operands after acceptance, time the done pulse
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [63:0] exp_p);
    logic [63:0] old;
    int cyc;
    old          = product;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    check({tag, "_prod_hold0"}, product, old);
    cyc = 0;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
      if (cyc == 1 && !done) check({tag, "_prod_hold1"}, product, old);
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_product"}, product, exp_p);
    tick();
    check({tag, "_done_clr"}, 64'(done), 64'd0);
    check({tag, "_busy_clr"}, 64'(busy), 64'd0);
    check({tag, "_prod_keep"}, product, exp_p);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    rst = 1'b0;
    tick();

    run_mul("m3x5", 32'd3, 32'd5, LAT_B5, 64'h0000_0000_0000_000F);
    run_mul("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_BFF, 64'hFFFF_FFFE_0000_0001);
    run_mul("mx0", 32'h1234_5678, 32'd0, LAT_B0, 64'd0);
    run_mul("mx1", 32'hDEAD_BEEF, 32'd1, LAT_B1, 64'h0000_0000_DEAD_BEEF);

    // Second start while busy must be ignored
    multiplicand = 32'd7;
    multiplier   = 32'd9;
    start        = 1'b1;
    tick();
    start  = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 4) begin
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        start        = 1'b1;
      end
      if (i == 5) start = 1'b0;
      if (done) pulses++;
    end
    check("ign_pulses", 64'(pulses), 64'd1);
    check("ign_product", product, 64'h3F);
    check("ign_busy", 64'(busy), 64'd0);

    // Reset in the middle of a run aborts it
    multiplicand = 32'h1_0000;
    multiplier   = 32'h1_0000;
    start        = 1'b1;
    tick();
    start  = 1'b0;
    pulses = 0;
    repeat (9) begin
      tick();
      if (done) pulses++;
    end
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    tick();
    rst = 1'b0;
    repeat (40) begin
      tick();
      if (done) pulses++;
    end
    check("abort_pulses", 64'(pulses), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    run_mul("restart", 32'h1_0000, 32'h1_0000, LAT_B10000, 64'h0000_0001_0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_seq_mul32
